// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and fetch FSM encoding.
package cpu_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned INST_BYTES = 4;

   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

   // One buffered fetch: instruction word and the address it came from.
   typedef struct packed {
      logic [WORD_W-1:0] inst;
      logic [WORD_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {inst, pc} entries; flush empties it and beats push.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic             head_valid,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_pop;

   assign do_pop     = pop && (cnt != '0);
   assign head       = mem[rd_ptr];
   assign head_valid = (cnt != '0);
   assign count      = cnt;

   // Storage, pointers and occupancy; a flush discards everything still queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         cnt <= cnt + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, redirect handling and imem request logic feeding a small queue.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_data,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [WORD_W-1:0] inst,
   output logic [WORD_W-1:0] inst_pc,
   output logic [WORD_W-1:0] inst_pcplus4
);

   localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
   localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(INST_BYTES);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_nxt;
   logic [WORD_W-1:0] pend_pc;
   logic [WORD_W-1:0] pend_nxt;
   logic [WORD_W-1:0] target;
   logic [CNT_W-1:0]  count;
   logic              push;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;

   // Redirect targets are word aligned; the low address bits are cleared.
   assign target    = redirect_pc & ~(PC_STEP - WORD_W'(1));
   assign imem_addr = pc;

   // State, pc and pending-target registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         pend_pc <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         pend_pc <= pend_nxt;
      end
   end

   // Next state, request and enqueue; DROP waits out a request made stale by a redirect.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      pend_nxt  = pend_pc;
      imem_req  = 1'b0;
      push      = 1'b0;
      case (state)
         FETCH: begin
            imem_req = (count < CNT_W'(DEPTH));
            if (redirect) begin
               if (imem_req && !imem_ack) begin
                  state_nxt = DROP;
                  pend_nxt  = target;
               end else begin
                  pc_nxt = target;
               end
            end else if (imem_req && imem_ack) begin
               push   = 1'b1;
               pc_nxt = pc + PC_STEP;
            end
         end
         DROP: begin
            imem_req = 1'b1;
            if (redirect) begin
               pend_nxt = target;
            end
            if (imem_ack) begin
               pc_nxt    = redirect ? target : pend_pc;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
      if (reset) begin
         imem_req = 1'b0;
      end
   end

   assign push_entry = '{inst: imem_data, pc: pc};

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (inst_valid && inst_ready),
      .flush      (redirect),
      .head       (head),
      .head_valid (inst_valid),
      .count      (count)
   );

   assign inst         = head.inst;
   assign inst_pc      = head.pc;
   assign inst_pcplus4 = head.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pcplus4;

   // Second instance starting near the top of the address space, zero-wait memory.
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_data;
   logic        w_redirect;
   logic [31:0] w_redirect_pc;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_inst;
   logic [31:0] w_pc;
   logic [31:0] w_pc4;

   int          lat;
   int          wait_cnt;
   int          evals;
   int          fails;
   logic        prev_pend;
   logic [31:0] prev_addr;

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_data    (imem_data),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_pcplus4 (inst_pcplus4)
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFF8),
      .DEPTH    (2)
   ) u_wrap (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (w_req),
      .imem_addr    (w_addr),
      .imem_ack     (w_ack),
      .imem_data    (w_data),
      .redirect     (w_redirect),
      .redirect_pc  (w_redirect_pc),
      .inst_valid   (w_valid),
      .inst_ready   (w_ready),
      .inst         (w_inst),
      .inst_pc      (w_pc),
      .inst_pcplus4 (w_pc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack once a request has waited lat cycles; forgets on reset or idle.
   always @(posedge clk) begin
      if (reset || !imem_req || imem_ack) wait_cnt <= 0;
      else                                wait_cnt <= wait_cnt + 1;
   end

   assign imem_ack      = imem_req && (wait_cnt >= lat);
   assign imem_data     = memdata(imem_addr);
   assign w_ack         = w_req;
   assign w_data        = memdata(w_addr);
   assign w_redirect    = 1'b0;
   assign w_redirect_pc = 32'h0;
   assign w_ready       = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      evals++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      evals++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one cycle; at mid-cycle verify an unacked request was held stable.
   task automatic step();
      @(negedge clk);
      if (!reset && prev_pend) begin
         chk1("hold_req", imem_req, 1'b1);
         chk("hold_addr", imem_addr, prev_addr);
      end
      prev_pend = imem_req && !imem_ack && !reset;
      prev_addr = imem_addr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      evals       = 0;
      fails       = 0;
      prev_pend   = 1'b0;
      prev_addr   = 32'h0;
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b1;
      lat         = 0;

      // Reset state
      step(); step(); #1;
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_pcplus4", inst_pcplus4, 32'h4);
      chk("rst_addr", imem_addr, 32'h0);
      chk1("wrap_rst_req", w_req, 1'b0);

      // Zero-wait streaming, plus the wrapping instance
      step(); reset = 1'b0; #1;
      chk1("s0_req", imem_req, 1'b1);
      chk("s0_addr", imem_addr, 32'h0);
      chk1("s0_valid", inst_valid, 1'b0);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
      step(); #1;
      chk("s1_addr", imem_addr, 32'h4);
      chk1("s1_valid", inst_valid, 1'b1);
      chk("s1_inst_pc", inst_pc, 32'h0);
      chk("s1_inst", inst, memdata(32'h0));
      chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
      chk("wrap_pc1", w_pc, 32'hFFFF_FFF8);
      step(); #1;
      chk("s2_addr", imem_addr, 32'h8);
      chk("s2_inst_pc", inst_pc, 32'h4);
      chk("wrap_addr2", w_addr, 32'h0);
      chk("wrap_pc2", w_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4_2", w_pc4, 32'h0);
      step(); #1;
      chk("s3_inst_pc", inst_pc, 32'h8);
      chk("s3_pcplus4", inst_pcplus4, 32'hC);
      chk("s3_inst", inst, memdata(32'h8));
      chk("wrap_pc3", w_pc, 32'h0);

      // Reset mid-stream, then backpressure
      step(); reset = 1'b1; inst_ready = 1'b0; #1;
      chk1("rst_mid_req", imem_req, 1'b0);
      step(); #1;
      chk1("rst_mid_valid", inst_valid, 1'b0);
      chk("rst_mid_addr", imem_addr, 32'h0);
      step(); reset = 1'b0; #1;
      chk1("bp0_req", imem_req, 1'b1);
      chk("bp0_addr", imem_addr, 32'h0);
      step(); #1;
      chk("bp1_inst_pc", inst_pc, 32'h0);
      chk("bp1_addr", imem_addr, 32'h4);
      step(); #1;
      chk1("bp2_req", imem_req, 1'b0);
      step(); step(); #1;
      chk1("bp4_req", imem_req, 1'b0);
      chk("bp4_inst_pc", inst_pc, 32'h0);
      chk("bp4_inst", inst, memdata(32'h0));
      step(); inst_ready = 1'b1; #1;
      chk1("bp5_valid", inst_valid, 1'b1);
      chk("bp5_inst_pc", inst_pc, 32'h0);
      step(); #1;
      chk("bp6_inst_pc", inst_pc, 32'h4);
      chk("bp6_addr", imem_addr, 32'h8);
      step(); #1;
      chk("bp7_inst_pc", inst_pc, 32'h8);
      chk("bp7_addr", imem_addr, 32'hC);

      // Three-cycle memory, redirect while the fetch of 0x8 is outstanding
      step(); reset = 1'b1; lat = 2; #1;
      step(); #1;
      step(); reset = 1'b0; #1;
      chk("lt0_addr", imem_addr, 32'h0);
      step(); step(); step(); #1;
      chk("lt3_inst_pc", inst_pc, 32'h0);
      chk("lt3_addr", imem_addr, 32'h4);
      step(); step(); step(); #1;
      chk("lt6_addr", imem_addr, 32'h8);
      chk("lt6_inst_pc", inst_pc, 32'h4);
      step(); redirect = 1'b1; redirect_pc = 32'h40; #1;
      chk("lt7_addr", imem_addr, 32'h8);
      step(); redirect = 1'b0; #1;
      chk1("drop_req", imem_req, 1'b1);
      chk("drop_addr", imem_addr, 32'h8);
      chk1("drop_valid", inst_valid, 1'b0);
      step(); #1;
      chk("rd_addr", imem_addr, 32'h40);
      step(); step(); #1;
      chk1("rd_wait_valid", inst_valid, 1'b0);
      step(); lat = 0; #1;
      chk("rd_inst_pc", inst_pc, 32'h40);
      chk("rd_inst", inst, memdata(32'h40));
      chk("rd_addr2", imem_addr, 32'h44);

      // Redirect to 0x103 together with ack and head handshake
      step(); redirect = 1'b1; redirect_pc = 32'h103; #1;
      chk1("ra_valid", inst_valid, 1'b1);
      chk("ra_inst_pc", inst_pc, 32'h44);
      chk("ra_addr", imem_addr, 32'h48);
      step(); redirect = 1'b0; #1;
      chk1("ra_flush_valid", inst_valid, 1'b0);
      chk("ra_new_addr", imem_addr, 32'h100);

      // Two redirects while dropping a slow fetch
      step(); lat = 4; redirect = 1'b1; redirect_pc = 32'h200; #1;
      chk("dd_inst_pc", inst_pc, 32'h100);
      chk("dd_addr", imem_addr, 32'h104);
      step(); redirect = 1'b0; #1;
      chk1("dd_valid", inst_valid, 1'b0);
      chk("dd_addr1", imem_addr, 32'h104);
      step(); redirect = 1'b1; redirect_pc = 32'h300; #1;
      step(); redirect = 1'b0; #1;
      step(); #1;
      chk("dd_addr4", imem_addr, 32'h104);
      step(); lat = 0; #1;
      chk("dd_new_addr", imem_addr, 32'h300);
      step(); inst_ready = 1'b0; lat = 3; #1;
      chk("dd_inst_pc2", inst_pc, 32'h300);
      chk("dd_inst2", inst, memdata(32'h300));

      // Reset with a request outstanding
      step(); reset = 1'b1; #1;
      chk1("ro_req", imem_req, 1'b0);
      chk("ro_held_pc", inst_pc, 32'h300);
      step(); #1;
      chk1("ro_valid", inst_valid, 1'b0);
      chk1("ro_req2", imem_req, 1'b0);
      chk("ro_inst_pc", inst_pc, 32'h0);
      step(); reset = 1'b0; inst_ready = 1'b1; lat = 0; #1;
      chk1("ro_restart_req", imem_req, 1'b1);
      chk("ro_restart_addr", imem_addr, 32'h0);
      step(); #1;
      chk1("ro_restart_valid", inst_valid, 1'b1);
      chk("ro_restart_pc", inst_pc, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
      $finish;
   end

endmodule
